serial_rx_slave: RTL and testbench
==================================

// Module: serial_rx_slave
// PURPOSE
//  Receive-side counterpart of the SFP/LVDS serial link. Deserialises the LVDS_DAT_OUT
//  bitstream into 11-bit frames and validates each one. From the valid frames it recovers the
//  interrupter pulse, the master/pro flags and the 3-bit option field. Pulse output is fail-safe:
//  forced low on loss of light, link timeout or before lock. Sits in drsstc_sfp_transceiver_top
//  on the slave board, driving OUT[]/LED_RX.
// PARAMETERS
//  CLKS_PER_BIT  8          clocks per serial bit (5 Mbit/s at 40 MHz); legal range >= 4
//  TIMEOUT_CYC   400        clocks without a valid frame before link drop (~4.5 frames)
//  LOCK_FRAMES   4          consecutive valid frames required to declare link up
//  LED_STRETCH   2000000    activity LED on-time in clocks (50 ms)
// PORTS
//  CLK_40M         in   1  clock CLK_40M
//  w_rst_n         in   1  reset w_rst_n, asynchronous, active-low
//  i_serial_data   in   1  raw rx bit from LVDS_DAT_OUT; asynchronous; idle high
//  i_sfp_loss_sig  in   1  SFP LOS; high = no light; asynchronous
//  o_pls           out  1  recovered interrupter pulse (gated by link_up)
//  o_is_master     out  1  frame bit1
//  o_is_pro        out  1  frame bit2
//  o_option        out  3  frame bits[5:3]
//  o_link_up       out  1  link locked
//  o_frame_valid   out  1  one-cycle strobe per accepted frame
//  o_frame_err     out  1  one-cycle strobe per rejected frame
//  o_err_cnt       out  8  saturating count of rejected frames
//  o_rcv_en_n      out  1  LVDS receiver enable (to LVDS_RCV_EN_N)
//  o_rx_led        out  2  [0] = link_up; [1] = stretched o_pls activity
// BEHAVIOUR
//  - Reset values: all outputs 0, except o_rcv_en_n = 1. o_rcv_en_n goes 0 on the first clock
//    after reset release. FSM enters IDLE; all counters are 0.
//  - i_serial_data and i_sfp_loss_sig each pass through a 2-FF synchroniser. All logic below
//    uses the synchronised copies.
//  - Frame, LSB first: start(0), d[7:0], even parity over d, stop(1). d[7:6] must equal 2'b10
//    (sync tag). d[0] = pulse.
//  - FSM states IDLE -> START -> DATA -> PARITY -> STOP -> IDLE.
//    IDLE: a synced 1->0 edge loads the bit timer and enters START.
//    Sampling: every bit is a 3-sample majority taken at timer offsets c-1, c and c+1, where
//    c = CLKS_PER_BIT/2.
//    START: majority = 1 -> false start; return to IDLE, no error strobe.
//    DATA: 8 bits. PARITY: 1 bit.
//    STOP: leave at the stop-bit centre so the next start edge is caught.
//  - Accept rule: stop = 1, parity even, and tag = 10.
//    Accepted frame, one clock after the stop centre: o_frame_valid pulses; pulse, flags and
//    option registers load; watchdog clears; lock counter increments (saturates at LOCK_FRAMES).
//    Rejected frame: o_frame_err pulses; o_err_cnt increments (saturates at 255); data
//    registers hold; lock counter clears.
//  - Watchdog counts clocks since the last accepted frame. On reaching TIMEOUT_CYC:
//    o_link_up = 0, pulse register = 0, lock counter = 0.
//    o_link_up = 1 once the lock counter reaches LOCK_FRAMES.
//  - o_pls = pulse register AND o_link_up. o_is_master, o_is_pro and o_option hold their last
//    accepted values regardless of link state.
//  - Synced LOS high: same effect as a timeout, applied immediately. In addition the FSM is
//    forced to IDLE and no strobes are issued while LOS is high. Relock requires LOCK_FRAMES
//    fresh frames.
//  - Simultaneous events: LOS beats accept, and accept beats timeout on the same clock.
//  - Latency: line edge -> o_pls <= 2 sync + 11*CLKS_PER_BIT + 1 + 1 frame of alignment slack.
//  - LED[1]: a rising edge of o_pls reloads the stretch counter to LED_STRETCH. LED[1] stays
//    high while the counter is non-zero.
// STRUCTURE
//  - Shared package drsstc_link_pkg: frame width (11), SYNC_TAG = 2'b10, data-field bit
//    indices (PLS = 0, MST = 1, PRO = 2, OPT = 5:3), FSM state encoding. Shared with
//    SerialTx_Master.
//  - One sub-module: sync_2ff (reused for both async inputs).
//  - FSM, bit timer, watchdog and LED stretcher stay inline.
// TESTING
//  1. Reset held, then released: all outputs 0, o_rcv_en_n = 1 during reset and 0 one clock
//     after release.
//  2. Send 4 frames of d = 0xBB (parity 0): o_frame_valid x4. o_link_up rises after the 4th
//     frame, with o_pls = 1, o_is_master = 1, o_is_pro = 0, o_option = 3'b111.
//  3. While locked, send d = 0xBB with parity = 1: o_frame_err pulses, o_err_cnt = 1,
//     o_pls stays 1. Lock counter clears, but link stays up until timeout.
//  4. Line held idle high after the last valid frame: exactly 400 clocks later o_link_up = 0
//     and o_pls = 0.
//  5. Assert i_sfp_loss_sig mid-frame: o_pls and o_link_up are 0 within 3 clocks, and no
//     strobe occurs. Deassert, send 4 x 0xBA: relock with o_pls = 0.
//  6. 1-clock low glitch on an idle line: no strobe and no error. Stop bit forced 0:
//     o_frame_err pulses and outputs hold.

Source files
------------

// File: rtl/drsstc_link_pkg.sv
// rtl/drsstc_link_pkg.sv - frame layout, field indices and rx FSM encoding for the SFP/LVDS link
package drsstc_link_pkg;

  localparam int FRAME_W = 11;
  localparam logic [1:0] SYNC_TAG = 2'b10;

  localparam int PLS_BIT = 0;
  localparam int MST_BIT = 1;
  localparam int PRO_BIT = 2;
  localparam int OPT_LSB = 3;
  localparam int OPT_MSB = 5;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchroniser for one asynchronous input
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic CLK_40M,
  input  logic w_rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge CLK_40M or negedge w_rst_n) begin
    if (!w_rst_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/serial_rx_slave.sv
// rtl/serial_rx_slave.sv - slave-side frame receiver: deserialise, validate, lock and fail-safe pulse output
module serial_rx_slave
  import drsstc_link_pkg::*;
#(
  parameter int CLKS_PER_BIT = 8,
  parameter int TIMEOUT_CYC  = 400,
  parameter int LOCK_FRAMES  = 4,
  parameter int LED_STRETCH  = 2000000
) (
  input  logic       CLK_40M,
  input  logic       w_rst_n,
  input  logic       i_serial_data,
  input  logic       i_sfp_loss_sig,
  output logic       o_pls,
  output logic       o_is_master,
  output logic       o_is_pro,
  output logic [2:0] o_option,
  output logic       o_link_up,
  output logic       o_frame_valid,
  output logic       o_frame_err,
  output logic [7:0] o_err_cnt,
  output logic       o_rcv_en_n,
  output logic [1:0] o_rx_led
);

  localparam int C  = CLKS_PER_BIT / 2;
  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int WW = $clog2(TIMEOUT_CYC + 1);
  localparam int LW = $clog2(LOCK_FRAMES + 1);
  localparam int SW = $clog2(LED_STRETCH + 1);

  logic            s_data, s_los, d_prev;
  rx_state_t       state, state_nxt;
  logic [TW-1:0]   timer;
  logic [2:0]      bit_idx;
  logic [7:0]      shreg;
  logic            par_bit;
  logic [1:0]      samp;
  logic            bit_end, at_c1, maj, frame_done, frame_ok, done_q, ok_q;
  logic [WW-1:0]   wd_cnt;
  logic [LW-1:0]   lock_cnt;
  logic [SW-1:0]   led_cnt;
  logic            pls_reg, link_up, pls_q;

  // Idle-high line: reset the data synchroniser high so release is not seen as a start edge
  sync_2ff #(.RESET_VAL(1'b1)) u_sync_data (
    .CLK_40M(CLK_40M), .w_rst_n(w_rst_n), .d(i_serial_data), .q(s_data)
  );
  sync_2ff #(.RESET_VAL(1'b1)) u_sync_los (
    .CLK_40M(CLK_40M), .w_rst_n(w_rst_n), .d(i_sfp_loss_sig), .q(s_los)
  );

  assign bit_end  = (timer == TW'(CLKS_PER_BIT - 1));
  assign at_c1    = (timer == TW'(C + 1));
  assign maj      = maj3(samp[1], samp[0], s_data);
  assign frame_ok = maj && !(^shreg ^ par_bit) && (shreg[7:6] == SYNC_TAG);

  always_ff @(posedge CLK_40M or negedge w_rst_n) begin
    if (!w_rst_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    frame_done = 1'b0;
    if (s_los) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:   if (d_prev && !s_data) state_nxt = ST_START;
        ST_START:  if (at_c1 && maj) state_nxt = ST_IDLE;
                   else if (bit_end) state_nxt = ST_DATA;
        ST_DATA:   if (bit_end && bit_idx == 3'd7) state_nxt = ST_PARITY;
        ST_PARITY: if (bit_end) state_nxt = ST_STOP;
        ST_STOP:   if (at_c1) begin
                     state_nxt  = ST_IDLE;
                     frame_done = 1'b1;
                   end
        default:   state_nxt = ST_IDLE;
      endcase
    end
  end

  // The edge cycle itself is bit time 0, so START begins at timer = 1
  always_ff @(posedge CLK_40M or negedge w_rst_n) begin
    if (!w_rst_n) begin
      d_prev  <= 1'b1;
      timer   <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      par_bit <= 1'b0;
      samp    <= '0;
      done_q  <= 1'b0;
      ok_q    <= 1'b0;
    end else begin
      d_prev <= s_data;
      done_q <= frame_done;
      ok_q   <= frame_ok;
      if (state == ST_IDLE)  timer <= TW'(1);
      else if (bit_end)      timer <= '0;
      else                   timer <= timer + TW'(1);
      if (timer == TW'(C - 1)) samp[1] <= s_data;
      if (timer == TW'(C))     samp[0] <= s_data;
      if (state == ST_START) bit_idx <= '0;
      if (state == ST_DATA) begin
        if (at_c1)   shreg   <= {maj, shreg[7:1]};
        if (bit_end) bit_idx <= bit_idx + 3'd1;
      end
      if (state == ST_PARITY && at_c1) par_bit <= maj;
    end
  end

  // Priority: LOS, then frame accept, then watchdog timeout
  always_ff @(posedge CLK_40M or negedge w_rst_n) begin
    if (!w_rst_n) begin
      o_rcv_en_n    <= 1'b1;
      o_frame_valid <= 1'b0;
      o_frame_err   <= 1'b0;
      o_err_cnt     <= '0;
      o_is_master   <= 1'b0;
      o_is_pro      <= 1'b0;
      o_option      <= '0;
      pls_reg       <= 1'b0;
      link_up       <= 1'b0;
      wd_cnt        <= '0;
      lock_cnt      <= '0;
    end else begin
      o_rcv_en_n    <= 1'b0;
      o_frame_valid <= 1'b0;
      o_frame_err   <= 1'b0;
      if (wd_cnt != WW'(TIMEOUT_CYC)) wd_cnt <= wd_cnt + WW'(1);
      if (s_los) begin
        pls_reg  <= 1'b0;
        link_up  <= 1'b0;
        lock_cnt <= '0;
        wd_cnt   <= WW'(TIMEOUT_CYC);
      end else if (done_q && ok_q) begin
        o_frame_valid <= 1'b1;
        pls_reg       <= shreg[PLS_BIT];
        o_is_master   <= shreg[MST_BIT];
        o_is_pro      <= shreg[PRO_BIT];
        o_option      <= shreg[OPT_MSB:OPT_LSB];
        wd_cnt        <= '0;
        if (lock_cnt != LW'(LOCK_FRAMES)) lock_cnt <= lock_cnt + LW'(1);
        if (lock_cnt >= LW'(LOCK_FRAMES - 1)) link_up <= 1'b1;
      end else begin
        if (done_q) begin
          o_frame_err <= 1'b1;
          lock_cnt    <= '0;
          if (o_err_cnt != 8'hFF) o_err_cnt <= o_err_cnt + 8'd1;
        end
        if (wd_cnt == WW'(TIMEOUT_CYC - 1)) begin
          link_up  <= 1'b0;
          pls_reg  <= 1'b0;
          lock_cnt <= '0;
        end
      end
    end
  end

  always_ff @(posedge CLK_40M or negedge w_rst_n) begin
    if (!w_rst_n) begin
      pls_q   <= 1'b0;
      led_cnt <= '0;
    end else begin
      pls_q <= o_pls;
      if (o_pls && !pls_q)       led_cnt <= SW'(LED_STRETCH);
      else if (led_cnt != '0)    led_cnt <= led_cnt - SW'(1);
    end
  end

  assign o_pls     = pls_reg & link_up;
  assign o_link_up = link_up;
  assign o_rx_led  = {(led_cnt != '0), link_up};

endmodule

// File: tb/tb_serial_rx_slave.sv
// tb/tb_serial_rx_slave.sv - scoreboard bench for serial_rx_slave with directed frames
module tb_serial_rx_slave;

  localparam int CPB = 8;
  localparam int GAP = 6;

  logic       CLK_40M = 1'b0;
  logic       w_rst_n = 1'b0;
  logic       ser = 1'b1;
  logic       los = 1'b0;
  logic       o_pls, o_is_master, o_is_pro, o_link_up, o_frame_valid, o_frame_err, o_rcv_en_n;
  logic [2:0] o_option;
  logic [7:0] o_err_cnt;
  logic [1:0] o_rx_led;

  typedef struct {
    logic       is_err;
    logic [7:0] err_cnt;
    logic       mst;
    logic       pro;
    logic [2:0] opt;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  int         last_valid_cyc = 0;
  logic [7:0] m_err = 8'd0;
  logic       m_mst = 1'b0;
  logic       m_pro = 1'b0;
  logic [2:0] m_opt = 3'd0;

  serial_rx_slave #(
    .CLKS_PER_BIT(CPB), .TIMEOUT_CYC(400), .LOCK_FRAMES(4), .LED_STRETCH(100)
  ) dut (
    .CLK_40M(CLK_40M), .w_rst_n(w_rst_n), .i_serial_data(ser), .i_sfp_loss_sig(los),
    .o_pls(o_pls), .o_is_master(o_is_master), .o_is_pro(o_is_pro), .o_option(o_option),
    .o_link_up(o_link_up), .o_frame_valid(o_frame_valid), .o_frame_err(o_frame_err),
    .o_err_cnt(o_err_cnt), .o_rcv_en_n(o_rcv_en_n), .o_rx_led(o_rx_led)
  );

  always #5 CLK_40M = ~CLK_40M;
  always @(posedge CLK_40M) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge CLK_40M);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par_flip, input logic stop_v);
    logic [10:0] fb;
    logic        ok;
    exp_t        e;
    fb = {stop_v, (^d) ^ par_flip, d, 1'b0};
    ok = stop_v && !par_flip && (d[7:6] == 2'b10);
    if (ok) begin
      m_mst = d[1];
      m_pro = d[2];
      m_opt = d[5:3];
    end else if (m_err != 8'hFF) begin
      m_err = m_err + 8'd1;
    end
    e.is_err = !ok; e.err_cnt = m_err; e.mst = m_mst; e.pro = m_pro; e.opt = m_opt;
    sb.push_back(e);
    for (int i = 0; i < 11; i++) begin
      ser = fb[i];
      wait_clk(CPB);
    end
    ser = 1'b1;
    wait_clk(GAP);
  endtask

  always @(negedge CLK_40M) begin
    if (w_rst_n && (o_frame_valid || o_frame_err)) begin
      if (sb.size() == 0) begin
        chk("unexpected_strobe", {o_frame_valid, o_frame_err}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("strobe_is_err", o_frame_err, e.is_err);
        chk("strobe_valid", o_frame_valid, !e.is_err);
        chk("err_cnt", o_err_cnt, e.err_cnt);
        chk("is_master", o_is_master, e.mst);
        chk("is_pro", o_is_pro, e.pro);
        chk("option", o_option, e.opt);
        if (o_frame_valid) last_valid_cyc = cyc;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [10:0] fb;
    repeat (3) @(negedge CLK_40M);
    chk("rst_rcv_en_n", o_rcv_en_n, 1);
    chk("rst_outputs", {o_pls, o_is_master, o_is_pro, o_option, o_link_up,
                        o_frame_valid, o_frame_err, o_err_cnt, o_rx_led}, 0);
    w_rst_n = 1'b1;
    #1 chk("rel_rcv_en_n_before_edge", o_rcv_en_n, 1);
    wait_clk(1);
    chk("rel_rcv_en_n_after_edge", o_rcv_en_n, 0);
    wait_clk(5);

    for (int k = 0; k < 4; k++) begin
      send_frame(8'hBB, 1'b0, 1'b1);
      if (k == 2) chk("no_lock_after_3", o_link_up, 0);
    end
    chk("lock_link_up", o_link_up, 1);
    chk("lock_pls", o_pls, 1);
    chk("lock_fields", {o_is_master, o_is_pro, o_option}, 5'b1_0_111);
    chk("lock_led", o_rx_led, 2'b11);

    send_frame(8'hBB, 1'b1, 1'b1);
    chk("perr_link_holds", o_link_up, 1);
    chk("perr_pls_holds", o_pls, 1);

    while (cyc < last_valid_cyc + 399) @(negedge CLK_40M);
    chk("wd_link_at_399", o_link_up, 1);
    @(negedge CLK_40M);
    chk("wd_link_at_400", o_link_up, 0);
    chk("wd_pls_at_400", o_pls, 0);
    chk("wd_led", o_rx_led, 2'b00);
    wait_clk(2);

    for (int k = 0; k < 4; k++) send_frame(8'hBB, 1'b0, 1'b1);
    chk("relock_link", o_link_up, 1);
    chk("relock_pls", o_pls, 1);

    fb = {1'b1, 1'b0, 8'hBB, 1'b0};
    for (int i = 0; i < 11; i++) begin
      ser = fb[i];
      if (i == 4) begin
        los = 1'b1;
        wait_clk(3);
        chk("los_pls", o_pls, 0);
        chk("los_link", o_link_up, 0);
        wait_clk(CPB - 3);
      end else begin
        wait_clk(CPB);
      end
    end
    ser = 1'b1;
    wait_clk(20);
    los = 1'b0;
    wait_clk(10);
    for (int k = 0; k < 4; k++) begin
      send_frame(8'hBA, 1'b0, 1'b1);
      if (k == 2) chk("los_no_lock_after_3", o_link_up, 0);
    end
    chk("los_relock_link", o_link_up, 1);
    chk("los_relock_pls", o_pls, 0);

    ser = 1'b0;
    wait_clk(1);
    ser = 1'b1;
    wait_clk(30);
    chk("glitch_err_cnt", o_err_cnt, 1);
    send_frame(8'hBA, 1'b0, 1'b0);
    chk("stop0_link_holds", o_link_up, 1);
    chk("stop0_fields_hold", {o_pls, o_is_master, o_is_pro, o_option}, 6'b0_1_0_111);

    wait_clk(20);
    chk("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
